alu_arbiter: RTL



---
 rtl/alu_arbiter_pkg.sv | 21 ++
 rtl/alu_arbiter_if.sv | 32 +++
 rtl/alu_arbiter_rr_arb2.sv | 19 +
 rtl/alu_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - ALU op codes, default widths and arbiter state encoding
package alu_arbiter_pkg;

    localparam int XLEN_DEF = 32;
    localparam int OPW_DEF  = 4;

    localparam logic [OPW_DEF-1:0] ALU_ADD = 4'b0000;
    localparam logic [OPW_DEF-1:0] ALU_SUB = 4'b0001;
    localparam logic [OPW_DEF-1:0] ALU_AND = 4'b0010;
    localparam logic [OPW_DEF-1:0] ALU_OR  = 4'b0011;
    localparam logic [OPW_DEF-1:0] ALU_XOR = 4'b0100;
    localparam logic [OPW_DEF-1:0] ALU_SLT = 4'b0101;
    localparam logic [OPW_DEF-1:0] ALU_SLL = 4'b0110;
    localparam logic [OPW_DEF-1:0] ALU_SRL = 4'b0111;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, response and ALU-side signals of the ALU arbiter
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int OPW  = OPW_DEF
) ();

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [2*OPW-1:0]  req_op;
    logic [2*XLEN-1:0] req_a;
    logic [2*XLEN-1:0] req_b;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [XLEN-1:0]   rsp_data;
    logic [OPW-1:0]    alu_control;
    logic [XLEN-1:0]   alu_src_a;
    logic [XLEN-1:0]   alu_src_b;
    logic [XLEN-1:0]   alu_result;

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready, alu_result,
        output req_ready, rsp_valid, rsp_data, alu_control, alu_src_a, alu_src_b
    );

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready, alu_result,
        input  req_ready, rsp_valid, rsp_data, alu_control, alu_src_a, alu_src_b
    );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// rtl/alu_arbiter_rr_arb2.sv - combinational two-way round-robin grant
module rr_arb2 (
    input  logic [1:0] req_valid_i,
    input  logic       last_i,
    output logic       any_o,
    output logic       gnt_o
);

    // On conflict the requester that did not win last time gets the grant.
    always_comb begin
        any_o = |req_valid_i;
        if (&req_valid_i) begin
            gnt_o = ~last_i;
        end else begin
            gnt_o = req_valid_i[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between two requesters; stats counters under ALU_ARB_STATS_EN
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
`ifdef ALU_ARB_STATS_EN
    parameter int CNT_W = 16,
`endif
    parameter int XLEN  = XLEN_DEF,
    parameter int OPW   = OPW_DEF
) (
    input  logic             clk,
    input  logic             reset,
`ifdef ALU_ARB_STATS_EN
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1,
    output logic [CNT_W-1:0] conflict_cnt,
`endif
    alu_arbiter_if.slave     bus
);

    arb_state_e      state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            any_valid;
    logic            gnt;
    logic            accept;

    rr_arb2 u_rr_arb2 (
        .req_valid_i (bus.req_valid),
        .last_i      (last_q),
        .any_o       (any_valid),
        .gnt_o       (gnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    // Releasing the owner and accepting the next operation share a cycle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        data_d  = data_q;
        accept  = any_valid && ((state_q == ARB_IDLE) || bus.rsp_ready[owner_q]);
        if (accept) begin
            state_d = ARB_HOLD;
            owner_d = gnt;
            last_d  = gnt;
            data_d  = bus.alu_result;
        end else if ((state_q == ARB_HOLD) && bus.rsp_ready[owner_q]) begin
            state_d = ARB_IDLE;
        end
    end

    always_comb begin
        bus.req_ready = 2'b00;
        if (accept && !reset) begin
            bus.req_ready[gnt] = 1'b1;
        end
        bus.rsp_valid = 2'b00;
        if (state_q == ARB_HOLD) begin
            bus.rsp_valid[owner_q] = 1'b1;
        end
        bus.rsp_data    = data_q;
        bus.alu_control = OPW'(ALU_ADD);
        bus.alu_src_a   = '0;
        bus.alu_src_b   = '0;
        if (any_valid) begin
            bus.alu_control = gnt ? bus.req_op[2*OPW-1:OPW]  : bus.req_op[OPW-1:0];
            bus.alu_src_a   = gnt ? bus.req_a[2*XLEN-1:XLEN] : bus.req_a[XLEN-1:0];
            bus.alu_src_b   = gnt ? bus.req_b[2*XLEN-1:XLEN] : bus.req_b[XLEN-1:0];
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt0_q, grant_cnt1_q, conflict_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_cnt0_q   <= '0;
            grant_cnt1_q   <= '0;
            conflict_cnt_q <= '0;
        end else if (accept) begin
            if (!gnt && !(&grant_cnt0_q)) begin
                grant_cnt0_q <= grant_cnt0_q + 1'b1;
            end
            if (gnt && !(&grant_cnt1_q)) begin
                grant_cnt1_q <= grant_cnt1_q + 1'b1;
            end
            if ((&bus.req_valid) && !(&conflict_cnt_q)) begin
                conflict_cnt_q <= conflict_cnt_q + 1'b1;
            end
        end
    end

    assign grant_cnt0   = grant_cnt0_q;
    assign grant_cnt1   = grant_cnt1_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
